ptos_sched: RTL and testbench
=============================

PTOS_SCHED -- requirements
Module: ptos_sched

Interface
REQ-001 Parameter: GAP, default 1, idle cycles (1..15) forced between end of STOP and next arbitration.
REQ-002 sclk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  channel 0 has a nibble pending; held high until ask0 is seen.
REQ-005 data0  input  4  channel 0 nibble; stable while req0 high.
REQ-006 req1  input  1  channel 1 request, same rules as req0.
REQ-007 data1  input  4  channel 1 nibble, same rules as data0.
REQ-008 ask0  output  1  one-cycle pulse: channel 0 nibble captured, present next.
REQ-009 ask1  output  1  one-cycle pulse: channel 1 nibble captured.
REQ-010 sdo  output  1  serial data line, idle high.
REQ-011 frame  output  1  high for every cycle of a frame (START through STOP).
REQ-012 busy  output  1  high from capture edge until last GAP cycle ends.

Function
REQ-013 FSM states SHALL be IDLE, START, ID, D3, D2, D1, D0, [PAR], STOP, GAP; all outputs registered.
REQ-014 In IDLE, sdo=1, frame=0, busy=0; a rising sclk edge with req0|req1 high SHALL capture the winner's nibble and channel id and enter START.
REQ-015 Arbitration SHALL be round-robin on a last-served pointer: single requester always wins; both requesting, the channel not last served wins.
REQ-016 The ask pulse for the winner SHALL be high exactly during the first START cycle; asks are never both high.
REQ-017 Per cycle: START sdo=0; ID sdo=channel id; D3..D0 sdo=captured bit MSB first; STOP sdo=1; frame=1 in all of these.
REQ-018 Frame length SHALL be 7 cycles (8 with PARITY_EN); latency from capture edge to START sdo=0 is one cycle.
REQ-019 GAP state SHALL hold sdo=1, frame=0, busy=1 for exactly GAP cycles via a 4-bit down-counter, then return to IDLE.
REQ-020 Requests are sampled only in IDLE; requests rising mid-frame wait, none are lost while req stays high.
REQ-021 Changes on dataN after capture SHALL NOT affect the frame in flight.
REQ-022 Back-to-back: a requester holding req high after ask with new data SHALL be served again only if the other channel is idle, else alternation.
REQ-023 GAP=0 is illegal; out-of-range values SHALL be clamped to 1..15 at elaboration.

Reset
REQ-024 rst high SHALL immediately force IDLE, sdo=1, frame=0, busy=0, ask0=ask1=0, pointer=channel 1 (so channel 0 wins first tie), GAP counter 0.
REQ-025 Reset mid-frame SHALL abort the frame with no further sdo activity; the captured nibble is discarded and no ask is reissued.

Configuration
REQ-026 Macro PTOS_PARITY_EN defined: PAR state inserted between D0 and STOP, sdo = even parity over id and 4 data bits (XOR of the five).
REQ-027 Macro PTOS_PARITY_EN undefined: no PAR state, D0 goes directly to STOP, 7-cycle frames.

Structure
REQ-028 Shared package ptos_pkg SHALL hold the state enumeration, FRAME_LEN constants (7/8) and the channel id width.
REQ-029 One sub-module ptos_shift SHALL hold the 6-bit load/shift register (id, data, parity) producing the serial bit; the FSM and arbiter stay in ptos_sched.

Verification
REQ-030 Reset, req0=1 data0=4'hA -> ask0 pulse in START; sdo sequence 0,0,1,0,1,0,1 with frame high 7 cycles; busy low after 1 GAP cycle.
REQ-031 req0=req1=1 held, data0=3 data1=C -> frames alternate ch0, ch1, ch0; ID bit 0,1,0; asks alternate, never coincident.
REQ-032 rst asserted during D2 of a frame -> same cycle sdo=1, frame=0, busy=0; after release, pending req1 served first frame with pointer reset.
REQ-033 PTOS_PARITY_EN, req1=1 data1=4'h7 -> 8-cycle frame, PAR bit = 1^0^1^1^1 = 0, then STOP=1.
REQ-034 GAP=4, req0 held with new data each ask -> exactly 4 idle-high cycles between STOP and next START; data change after ask not seen in current frame.

Source files
------------

// File: rtl/ptos_pkg.sv
// ptos_pkg: shared types and constants for the two-channel nibble serialiser.
//   state_e        frame sequencer states
//   FRAME_LEN      cycles from START to STOP inclusive (7, or 8 with PTOS_PARITY_EN)
//   ID_W / DATA_W  channel id and nibble widths; SR_W is the id+data+parity shifter width
//   gap_clamp()    folds the GAP parameter into the legal 1..15 range
// Optional feature macro: PTOS_PARITY_EN (adds an even-parity bit before STOP).
package ptos_pkg;

    localparam int unsigned ID_W           = 1;
    localparam int unsigned DATA_W         = 4;
    localparam int unsigned SR_W           = ID_W + DATA_W + 1;
    localparam int unsigned GAP_CNT_W      = 4;
    localparam int unsigned FRAME_LEN_BASE = 7;
    localparam int unsigned FRAME_LEN_PAR  = 8;

`ifdef PTOS_PARITY_EN
    localparam int unsigned FRAME_LEN = FRAME_LEN_PAR;
`else
    localparam int unsigned FRAME_LEN = FRAME_LEN_BASE;
`endif

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ID    = 4'd2,
        S_D3    = 4'd3,
        S_D2    = 4'd4,
        S_D1    = 4'd5,
        S_D0    = 4'd6,
        S_PAR   = 4'd7,
        S_STOP  = 4'd8,
        S_GAP   = 4'd9
    } state_e;

    // Clamp the inter-frame gap to what the 4-bit counter can express, never zero.
    function automatic int unsigned gap_clamp(input int g);
        if (g < 1) begin
            return 1;
        end
        if (g > 15) begin
            return 15;
        end
        return int'(g);
    endfunction

endpackage

// File: rtl/ptos_sched_if.sv
// ptos_sched_if: request/data/handshake and serial output bundle for ptos_sched.
//   req0/req1    channel requests (held until the matching ask pulse)
//   data0/data1  channel nibbles, stable while the request is high
//   ask0/ask1    one-cycle capture acknowledge, high during the first START cycle
//   sdo          serial line, idle high
//   frame        high START..STOP
//   busy         high from capture until the end of the inter-frame gap
// Modports: master drives requests/data, slave is the scheduler.
interface ptos_sched_if;
    import ptos_pkg::*;

    logic              req0;
    logic              req1;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              ask0;
    logic              ask1;
    logic              sdo;
    logic              frame;
    logic              busy;

    modport master (
        output req0, req1, data0, data1,
        input  ask0, ask1, sdo, frame, busy
    );

    modport slave (
        input  req0, req1, data0, data1,
        output ask0, ask1, sdo, frame, busy
    );

endinterface

// File: rtl/ptos_shift.sv
// ptos_shift: frame payload holder. Loads {id, nibble, even parity} on capture and
// shifts MSB-first; bit_o is the bit to place on the line at the next shift.
//   sclk, rst   clock and asynchronous active-high reset
//   load_i      capture the id/nibble of the arbitration winner
//   shift_i     advance to the next payload bit
//   id_i        winning channel id
//   data_i      winning channel nibble
//   bit_o       current head bit of the payload
// The parity slot is only reached when PTOS_PARITY_EN is defined.
module ptos_shift
    import ptos_pkg::*;
(
    input  logic              sclk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [ID_W-1:0]   id_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              bit_o
);

    logic [SR_W-1:0] sr_q;
    logic [SR_W-1:0] sr_d;

    // Load has priority; shifting fills with the line's idle level.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = {id_i, data_i, ^{id_i, data_i}};
        end else if (shift_i) begin
            sr_d = {sr_q[SR_W-2:0], 1'b1};
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            sr_q <= '1;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = sr_q[SR_W-1];

endmodule

// File: rtl/ptos_sched.sv
// ptos_sched: two-channel round-robin nibble serialiser.
// Frame on sdo: START(0), ID, D3..D0, [PAR], STOP(1), followed by GAP idle-high
// cycles with busy still asserted, then IDLE where requests are arbitrated again.
//   sclk, rst   clock and asynchronous active-high reset
//   bus         ptos_sched_if.slave (req/data in, ask/sdo/frame/busy out)
//   GAP         inter-frame gap in cycles, clamped to 1..15
// Macro PTOS_PARITY_EN inserts an even-parity bit (XOR of id and nibble) before STOP.
module ptos_sched
    import ptos_pkg::*;
#(
    parameter int GAP = 1
) (
    input  logic        sclk,
    input  logic        rst,
    ptos_sched_if.slave bus
);

    localparam int unsigned         GAP_C   = gap_clamp(GAP);
    localparam logic [GAP_CNT_W-1:0] GAP_CNT = GAP_CNT_W'(GAP_C);

    state_e                 state_q;
    logic                   last_q;
    logic [GAP_CNT_W-1:0]   gap_cnt_q;
    logic                   sdo_q;
    logic                   frame_q;
    logic                   busy_q;
    logic                   ask0_q;
    logic                   ask1_q;

    logic                   any_req_c;
    logic                   win_c;
    logic [DATA_W-1:0]      cap_data_c;
    logic                   load_c;
    logic                   shift_c;
    logic                   bit_c;

    // Round robin: a lone requester wins; on a tie the channel not served last wins.
    always_comb begin
        any_req_c  = bus.req0 | bus.req1;
        win_c      = (bus.req0 & bus.req1) ? ~last_q : bus.req1;
        cap_data_c = win_c ? bus.data1 : bus.data0;
        load_c     = (state_q == S_IDLE) & any_req_c;
        shift_c    = 1'b0;
        unique case (state_q)
            S_START, S_ID, S_D3, S_D2, S_D1, S_D0: shift_c = 1'b1;
            default:                               shift_c = 1'b0;
        endcase
    end

    ptos_shift u_shift (
        .sclk    (sclk),
        .rst     (rst),
        .load_i  (load_c),
        .shift_i (shift_c),
        .id_i    (win_c),
        .data_i  (cap_data_c),
        .bit_o   (bit_c)
    );

    // Sequencer with outputs registered alongside the state they belong to.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            last_q    <= 1'b1;
            gap_cnt_q <= '0;
            sdo_q     <= 1'b1;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            ask0_q    <= 1'b0;
            ask1_q    <= 1'b0;
        end else begin
            ask0_q <= 1'b0;
            ask1_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_req_c) begin
                        state_q <= S_START;
                        last_q  <= win_c;
                        ask0_q  <= ~win_c;
                        ask1_q  <= win_c;
                        sdo_q   <= 1'b0;
                        frame_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    state_q <= S_ID;
                    sdo_q   <= bit_c;
                end
                S_ID: begin
                    state_q <= S_D3;
                    sdo_q   <= bit_c;
                end
                S_D3: begin
                    state_q <= S_D2;
                    sdo_q   <= bit_c;
                end
                S_D2: begin
                    state_q <= S_D1;
                    sdo_q   <= bit_c;
                end
                S_D1: begin
                    state_q <= S_D0;
                    sdo_q   <= bit_c;
                end
                S_D0: begin
`ifdef PTOS_PARITY_EN
                    state_q <= S_PAR;
                    sdo_q   <= bit_c;
`else
                    state_q <= S_STOP;
                    sdo_q   <= 1'b1;
`endif
                end
                S_PAR: begin
                    state_q <= S_STOP;
                    sdo_q   <= 1'b1;
                end
                S_STOP: begin
                    state_q   <= S_GAP;
                    sdo_q     <= 1'b1;
                    frame_q   <= 1'b0;
                    gap_cnt_q <= GAP_CNT;
                end
                S_GAP: begin
                    // Counter holds the cycles still to spend in GAP, this one included.
                    if (gap_cnt_q <= GAP_CNT_W'(1)) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        gap_cnt_q <= '0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GAP_CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    sdo_q     <= 1'b1;
                    frame_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    gap_cnt_q <= '0;
                end
            endcase
        end
    end

    assign bus.ask0  = ask0_q;
    assign bus.ask1  = ask1_q;
    assign bus.sdo   = sdo_q;
    assign bus.frame = frame_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ptos_sched.sv
// tb_ptos_sched: randomized bench for ptos_sched. Two instances (GAP=4 and GAP=0,
// the latter clamped to 1) run against a frame-level reference model: on each
// arbitration the model expands the whole expected waveform (frame bits, gap) into
// a per-cycle queue. Honours PTOS_PARITY_EN.
module tb_ptos_sched;

    typedef struct packed {
        logic [3:0] ph;
        logic       ask1;
        logic       ask0;
        logic       busy;
        logic       frame;
        logic       sdo;
    } step_t;

    localparam logic [3:0] PH_IDLE  = 4'd0;
    localparam logic [3:0] PH_START = 4'd1;
    localparam logic [3:0] PH_ID    = 4'd2;
    localparam logic [3:0] PH_D3    = 4'd3;
    localparam logic [3:0] PH_D2    = 4'd4;
    localparam logic [3:0] PH_D1    = 4'd5;
    localparam logic [3:0] PH_D0    = 4'd6;
    localparam logic [3:0] PH_PAR   = 4'd7;
    localparam logic [3:0] PH_STOP  = 4'd8;
    localparam logic [3:0] PH_GAP   = 4'd9;

    localparam step_t IDLE_STEP = '{ph: PH_IDLE, ask1: 1'b0, ask0: 1'b0,
                                    busy: 1'b0, frame: 1'b0, sdo: 1'b1};

    logic sclk = 1'b0;
    logic rst  = 1'b1;

    logic       req0_v  [2];
    logic       req1_v  [2];
    logic [3:0] data0_v [2];
    logic [3:0] data1_v [2];

    int     gap_m  [2] = '{4, 1};
    logic   last_m [2];
    step_t  tl     [2][$];

    int n_cmp = 0;
    int n_err = 0;
    bit rst_done = 1'b0;

    ptos_sched_if bus0 ();
    ptos_sched_if bus1 ();

    assign bus0.req0  = req0_v[0];
    assign bus0.req1  = req1_v[0];
    assign bus0.data0 = data0_v[0];
    assign bus0.data1 = data1_v[0];
    assign bus1.req0  = req0_v[1];
    assign bus1.req1  = req1_v[1];
    assign bus1.data0 = data0_v[1];
    assign bus1.data1 = data1_v[1];

    ptos_sched #(.GAP(4)) u_dut_g4 (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus0)
    );

    ptos_sched #(.GAP(0)) u_dut_g0 (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus1)
    );

    always #5 sclk = ~sclk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b (ask1 ask0 busy frame sdo)",
                     tag, $time, got[4:0], exp[4:0]);
        end
    endtask

    function automatic logic [4:0] obs(input int i);
        if (i == 0) begin
            return {bus0.ask1, bus0.ask0, bus0.busy, bus0.frame, bus0.sdo};
        end
        return {bus1.ask1, bus1.ask0, bus1.busy, bus1.frame, bus1.sdo};
    endfunction

    function automatic step_t cur_step(input int i);
        if (tl[i].size() != 0) begin
            return tl[i][0];
        end
        return IDLE_STEP;
    endfunction

    task automatic push(input int i, input logic [3:0] ph, input logic a1, input logic a0,
                        input logic b, input logic f, input logic s);
        step_t st;
        st = '{ph: ph, ask1: a1, ask0: a0, busy: b, frame: f, sdo: s};
        tl[i].push_back(st);
    endtask

    // Advance the model across one clock edge using the inputs present at that edge.
    task automatic model_step(input int i);
        logic       w;
        logic [3:0] d;
        if (tl[i].size() == 0) begin
            if (req0_v[i] | req1_v[i]) begin
                if (req0_v[i] & req1_v[i]) begin
                    w = ~last_m[i];
                end else begin
                    w = req1_v[i];
                end
                d         = w ? data1_v[i] : data0_v[i];
                last_m[i] = w;
                push(i, PH_START, w, ~w, 1'b1, 1'b1, 1'b0);
                push(i, PH_ID, 1'b0, 1'b0, 1'b1, 1'b1, w);
                for (int k = 3; k >= 0; k--) begin
                    push(i, PH_D0 - 4'(k), 1'b0, 1'b0, 1'b1, 1'b1, d[k]);
                end
`ifdef PTOS_PARITY_EN
                push(i, PH_PAR, 1'b0, 1'b0, 1'b1, 1'b1, w ^ d[3] ^ d[2] ^ d[1] ^ d[0]);
`endif
                push(i, PH_STOP, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                for (int k = 0; k < gap_m[i]; k++) begin
                    push(i, PH_GAP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
                end
            end
        end else begin
            void'(tl[i].pop_front());
        end
    endtask

    // Requester behaviour: on its ask a channel loads new data and keeps or drops req.
    task automatic agents(input int i);
        step_t cur;
        cur = cur_step(i);
        if (cur.ask0) begin
            data0_v[i] = 4'($urandom);
            req0_v[i]  = ($urandom_range(1, 0) != 0);
        end else if (!req0_v[i] && $urandom_range(2, 0) == 0) begin
            req0_v[i]  = 1'b1;
            data0_v[i] = 4'($urandom);
        end
        if (cur.ask1) begin
            data1_v[i] = 4'($urandom);
            req1_v[i]  = ($urandom_range(1, 0) != 0);
        end else if (!req1_v[i] && $urandom_range(2, 0) == 0) begin
            req1_v[i]  = 1'b1;
            data1_v[i] = 4'($urandom);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req0_v[i]  = 1'b0;
            req1_v[i]  = 1'b0;
            data0_v[i] = 4'h0;
            data1_v[i] = 4'h0;
            last_m[i]  = 1'b1;
        end

        repeat (2) @(posedge sclk);
        #1;
        check_eq("reset_g4", 8'(obs(0)), 8'(5'b00001));
        check_eq("reset_g0", 8'(obs(1)), 8'(5'b00001));
        rst = 1'b0;

        // First transaction: channel 0 alone with nibble A.
        for (int i = 0; i < 2; i++) begin
            req0_v[i]  = 1'b1;
            data0_v[i] = 4'hA;
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge sclk);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    model_step(i);
                end
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                step_t e;
                e = cur_step(i);
                check_eq($sformatf("out_g%0d", gap_m[i]), 8'(obs(i)), 8'(e[4:0]));
            end
            if (rst) begin
                rst = 1'b0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    agents(i);
                end
                // Abort a frame mid-data; leave only channel 1 pending afterwards.
                if (!rst_done && cyc > 300 && cur_step(0).ph == PH_D2) begin
                    #2;
                    rst = 1'b1;
                    #1;
                    check_eq("async_rst_g4", 8'(obs(0)), 8'(5'b00001));
                    check_eq("async_rst_g0", 8'(obs(1)), 8'(5'b00001));
                    for (int i = 0; i < 2; i++) begin
                        tl[i].delete();
                        last_m[i]  = 1'b1;
                        req0_v[i]  = 1'b0;
                        req1_v[i]  = 1'b1;
                        data1_v[i] = 4'($urandom);
                    end
                    rst_done = 1'b1;
                end
            end
        end

        check_eq("rst_scenario_reached", 8'(rst_done), 8'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
